sram_byte_ctrl: RTL and testbench

Byte-serial command front end that drives the 16 KB SRAM macro wrapper (`sram16_top`) directly.
- Accepts an 8-bit valid/ready command stream and assembles 12-bit word addresses and 32-bit write data.
- Issues single-cycle SRAM accesses with byte masks and auto-increment bursts.
- Returns read words as a 4-byte valid/ready stream, LSB first.
- Sits between the chip's 8-bit I/O pins and the SRAM; it is the only master of the macro.

---
 rtl/sram_ctrl_pkg.sv | 31 +++
 rtl/sram_byte_shifter.sv | 26 ++
 rtl/sram_byte_ctrl.sv | 139 +++++++++++++
 tb/tb_sram_byte_ctrl.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared types and field positions for the byte-serial SRAM command front end.
package sram_ctrl_pkg;

  localparam int ADDR_W         = 12;
  localparam int DATA_W         = 32;
  localparam int BYTES_PER_WORD = 4;

  localparam int CMD_WR_BIT   = 7;
  localparam int CMD_LEN_MSB  = 6;
  localparam int CMD_LEN_LSB  = 4;
  localparam int CMD_MASK_MSB = 3;
  localparam int CMD_MASK_LSB = 0;

  typedef enum logic [2:0] {
    ST_CMD,
    ST_ADDR_HI,
    ST_ADDR_LO,
    ST_DATA,
    ST_WRITE,
    ST_READ,
    ST_READ_WAIT,
    ST_SEND
  } state_t;

  // Latched portion of the command byte; the length lives in the word counter.
  typedef struct packed {
    logic       wr;
    logic [3:0] mask;
  } cmd_t;

endpackage

// File: rtl/sram_byte_shifter.sv
// Word-wide shift register: parallel load, or shift right one byte with a byte entering at the top.
// Latency: one cycle from load/shift to q.
// Backpressure: none; the owner gates load/shift with its own handshakes.
module sram_byte_shifter #(
  parameter int W = sram_ctrl_pkg::DATA_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_dat,
  input  logic         shift,
  input  logic [7:0]   shift_in,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= load_dat;
    end else if (shift) begin
      q <= {shift_in, q[W-1:8]};
    end
  end

endmodule

// File: rtl/sram_byte_ctrl.sv
// Byte-serial command front end and sole master of the SRAM macro.
// Latency: write access the cycle after the 4th data byte; first read byte 3 cycles after addr_lo.
// Backpressure: in_valid/out_ready stall indefinitely; input and output handshakes never overlap.
module sram_byte_ctrl #(
  parameter int ADDR_W = sram_ctrl_pkg::ADDR_W,
  parameter int DATA_W = sram_ctrl_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  output logic              sram_cs,
  output logic [3:0]        sram_wen,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              busy
);
  import sram_ctrl_pkg::*;

  state_t            state, state_nxt;
  cmd_t              cmd_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        remain_q;
  logic [1:0]        byte_cnt_q;
  logic              run_q;

  logic              in_fire, out_fire;
  logic              last_byte, last_word, word_done;
  logic              wr_shift, rd_load, rd_shift;
  logic [DATA_W-1:0] wr_word, rd_word;
  logic              unused_rd_hi;

  // run_q keeps in_ready low during the reset cycles themselves.
  assign in_ready  = run_q & (state inside {ST_CMD, ST_ADDR_HI, ST_ADDR_LO, ST_DATA});
  assign out_valid = (state == ST_SEND);
  assign busy      = (state != ST_CMD);
  assign sram_cs   = ((state == ST_WRITE) && (cmd_q.mask != 4'b0000)) || (state == ST_READ);
  assign sram_wen  = (state == ST_WRITE) ? cmd_q.mask : 4'b0000;
  assign sram_addr = addr_q;
  assign sram_wdata = wr_word;
  assign out_data  = rd_word[7:0];
  assign unused_rd_hi = ^rd_word[DATA_W-1:8];

  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign last_byte = (byte_cnt_q == 2'd3);
  assign last_word = (remain_q == 4'd1);
  assign word_done = (state == ST_WRITE) || (rd_shift && last_byte);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_CMD;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    wr_shift  = 1'b0;
    rd_load   = 1'b0;
    rd_shift  = 1'b0;
    unique case (state)
      ST_CMD:     if (in_fire) state_nxt = ST_ADDR_HI;
      ST_ADDR_HI: if (in_fire) state_nxt = ST_ADDR_LO;
      ST_ADDR_LO: if (in_fire) state_nxt = cmd_q.wr ? ST_DATA : ST_READ;
      ST_DATA: begin
        if (in_fire) begin
          wr_shift = 1'b1;
          if (last_byte) state_nxt = ST_WRITE;
        end
      end
      ST_WRITE:     state_nxt = last_word ? ST_CMD : ST_DATA;
      ST_READ:      state_nxt = ST_READ_WAIT;
      ST_READ_WAIT: begin
        rd_load   = 1'b1;
        state_nxt = ST_SEND;
      end
      ST_SEND: begin
        if (out_fire) begin
          rd_shift = 1'b1;
          if (last_byte) state_nxt = last_word ? ST_CMD : ST_READ;
        end
      end
      default: state_nxt = ST_CMD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_q      <= '0;
      addr_q     <= '0;
      remain_q   <= '0;
      byte_cnt_q <= '0;
      run_q      <= 1'b0;
    end else begin
      run_q <= 1'b1;
      if ((state == ST_CMD) && in_fire) begin
        cmd_q.wr   <= in_data[CMD_WR_BIT];
        cmd_q.mask <= in_data[CMD_MASK_MSB:CMD_MASK_LSB];
        remain_q   <= {1'b0, in_data[CMD_LEN_MSB:CMD_LEN_LSB]} + 4'd1;
      end
      if ((state == ST_ADDR_HI) && in_fire) addr_q[ADDR_W-1:8] <= in_data[ADDR_W-9:0];
      if ((state == ST_ADDR_LO) && in_fire) addr_q[7:0] <= in_data;
      // One byte counter serves both the write assembly and the read emission.
      if (wr_shift || rd_shift) byte_cnt_q <= byte_cnt_q + 2'd1;
      if (word_done) begin
        addr_q   <= addr_q + 1'b1;
        remain_q <= remain_q - 4'd1;
      end
    end
  end

  sram_byte_shifter #(.W(DATA_W)) u_wr_shift (
    .clk      (clk),
    .rst      (rst),
    .load     (1'b0),
    .load_dat ('0),
    .shift    (wr_shift),
    .shift_in (in_data),
    .q        (wr_word)
  );

  sram_byte_shifter #(.W(DATA_W)) u_rd_shift (
    .clk      (clk),
    .rst      (rst),
    .load     (rd_load),
    .load_dat (sram_rdata),
    .shift    (rd_shift),
    .shift_in (8'd0),
    .q        (rd_word)
  );

endmodule

// File: tb/tb_sram_byte_ctrl.sv
// Bench for sram_byte_ctrl: directed table, hand-written corner sequences and random traffic vs. a memory model.
module tb_sram_byte_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] sram_addr;
  logic [31:0] sram_wdata;
  logic        sram_cs;
  logic [3:0]  sram_wen;
  logic [31:0] sram_rdata;
  logic        busy;

  always #5 clk = ~clk;

  sram_byte_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_cs    (sram_cs),
    .sram_wen   (sram_wen),
    .sram_rdata (sram_rdata),
    .busy       (busy)
  );

  // SRAM macro stand-in: byte-masked write, registered read.
  logic [31:0] mem [0:4095];
  logic        clr_mem;
  always @(posedge clk) begin
    if (clr_mem) begin
      for (int i = 0; i < 4096; i++) mem[i] <= '0;
      sram_rdata <= '0;
    end else if (sram_cs) begin
      if (sram_wen == 4'b0000) sram_rdata <= mem[sram_addr];
      else for (int j = 0; j < 4; j++)
        if (sram_wen[j]) mem[sram_addr][8*j +: 8] <= sram_wdata[8*j +: 8];
    end
  end

  // Access log: edge count, address, enables and data of each cs cycle.
  typedef struct {
    int          e;
    logic [11:0] a;
    logic [3:0]  wen;
    logic [31:0] wd;
  } acc_t;
  acc_t acc_q[$];
  int   cs_cnt = 0;
  int   ecnt = 0;
  always @(posedge clk) ecnt <= ecnt + 1;
  always @(negedge clk) if (sram_cs) begin
    cs_cnt++;
    acc_q.push_back('{ecnt, sram_addr, sram_wen, sram_wdata});
  end

  logic [31:0] ref_mem [0:4095];
  int errs = 0, checks = 0;
  int wr_last_e, rd_addr_e, rd_first_e;
  int rand_gap = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errs++;
    $display("FAIL %s: timeout waiting for handshake", name);
  endtask

  task automatic send_byte(input logic [7:0] b, output int acc_e);
    int t = 0;
    if (rand_gap != 0) repeat ($urandom_range(0, 2)) @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) timeout_fail("in_handshake");
    @(posedge clk);
    @(negedge clk);
    acc_e    = ecnt;
    in_valid = 1'b0;
  endtask

  task automatic recv_byte(output logic [7:0] b, output int first_e);
    int t = 0;
    if (rand_gap != 0) repeat ($urandom_range(0, 2)) @(negedge clk);
    out_ready = 1'b1;
    while (!out_valid && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) timeout_fail("out_handshake");
    first_e = ecnt;
    b       = out_data;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic write_txn(input logic [11:0] a, input int len, input logic [3:0] mask,
                           input logic [31:0] words [8]);
    int e;
    logic [11:0] wa;
    send_byte({1'b1, 3'(len - 1), mask}, e);
    send_byte({4'h0, a[11:8]}, e);
    send_byte(a[7:0], e);
    for (int w = 0; w < len; w++) begin
      for (int j = 0; j < 4; j++) send_byte(words[w][8*j +: 8], e);
      wr_last_e = (w == 0) ? e : wr_last_e;
    end
    repeat (2) @(negedge clk);
    for (int w = 0; w < len; w++) begin
      wa = a + 12'(w);
      for (int j = 0; j < 4; j++) if (mask[j]) ref_mem[wa][8*j +: 8] = words[w][8*j +: 8];
    end
  endtask

  task automatic read_txn(input logic [11:0] a, input int len, output logic [31:0] got [8]);
    int e;
    logic [7:0] b;
    send_byte({1'b0, 3'(len - 1), 4'h0}, e);
    send_byte({4'h0, a[11:8]}, e);
    send_byte(a[7:0], rd_addr_e);
    for (int w = 0; w < len; w++) begin
      for (int j = 0; j < 4; j++) begin
        recv_byte(b, e);
        if (w == 0 && j == 0) rd_first_e = e;
        got[w][8*j +: 8] = b;
      end
    end
    @(negedge clk);
  endtask

  typedef struct {
    logic [11:0] addr;
    logic [3:0]  mask;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    int          exp_cs;
  } vec_t;
  vec_t tbl [6];

  logic [31:0] wbuf [8];
  logic [31:0] rbuf [8];
  int          cs0, bad, e;
  logic [7:0]  b;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{12'h123, 4'hF, 32'h12345678, 32'h12345678, 1};
    tbl[1] = '{12'h200, 4'h5, 32'hAABBCCDD, 32'h00BB00DD, 1};
    tbl[2] = '{12'h200, 4'hA, 32'h11223344, 32'h11BB33DD, 1};
    tbl[3] = '{12'h200, 4'h0, 32'hFFFFFFFF, 32'h11BB33DD, 0};
    tbl[4] = '{12'hFFF, 4'h8, 32'hDEADBEEF, 32'hDE000000, 1};
    tbl[5] = '{12'h000, 4'h3, 32'hCAFEF00D, 32'h0000F00D, 1};
    for (int i = 0; i < 4096; i++) ref_mem[i] = '0;
    for (int i = 0; i < 8; i++) wbuf[i] = '0;

    // Reset with in_valid asserted: every output must read 0.
    rst = 1'b1; clr_mem = 1'b1; in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {24'd0, out_data}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_cs", {31'd0, sram_cs}, 32'd0);
    check("rst_wen", {28'd0, sram_wen}, 32'd0);
    check("rst_addr", {20'd0, sram_addr}, 32'd0);
    check("rst_wdata", sram_wdata, 32'd0);
    in_valid = 1'b0; out_ready = 1'b0; rst = 1'b0; clr_mem = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("post_rst_busy", {31'd0, busy}, 32'd0);
    check("post_rst_cs", {31'd0, sram_cs}, 32'd0);

    // Directed single-word write/read table.
    for (int i = 0; i < 6; i++) begin
      acc_q.delete();
      cs0 = cs_cnt;
      wbuf[0] = tbl[i].wd;
      write_txn(tbl[i].addr, 1, tbl[i].mask, wbuf);
      check($sformatf("tbl%0d_cs_count", i), cs_cnt - cs0, tbl[i].exp_cs);
      if (tbl[i].exp_cs == 1 && acc_q.size() > 0) begin
        check($sformatf("tbl%0d_wr_addr", i), {20'd0, acc_q[0].a}, {20'd0, tbl[i].addr});
        check($sformatf("tbl%0d_wr_wen", i), {28'd0, acc_q[0].wen}, {28'd0, tbl[i].mask});
        check($sformatf("tbl%0d_wr_data", i), acc_q[0].wd, tbl[i].wd);
        if (i == 0) check("write_latency", acc_q[0].e - wr_last_e, 0);
      end
      read_txn(tbl[i].addr, 1, rbuf);
      check($sformatf("tbl%0d_rd_data", i), rbuf[0], tbl[i].exp_rd);
      check($sformatf("tbl%0d_rd_latency", i), rd_first_e - rd_addr_e, 2);
    end

    // Burst of 4 wrapping past 0xFFF.
    acc_q.delete();
    for (int i = 0; i < 4; i++) wbuf[i] = 32'(i + 1);
    write_txn(12'hFFE, 4, 4'hF, wbuf);
    check("wrap_cs_count", acc_q.size(), 4);
    if (acc_q.size() == 4) begin
      check("wrap_addr0", {20'd0, acc_q[0].a}, 32'h0FFE);
      check("wrap_addr1", {20'd0, acc_q[1].a}, 32'h0FFF);
      check("wrap_addr2", {20'd0, acc_q[2].a}, 32'h0000);
      check("wrap_addr3", {20'd0, acc_q[3].a}, 32'h0001);
    end
    read_txn(12'hFFE, 4, rbuf);
    for (int i = 0; i < 4; i++) check($sformatf("wrap_rd%0d", i), rbuf[i], 32'(i + 1));

    // Output backpressure on the second byte.
    wbuf[0] = 32'h12345678;
    write_txn(12'h123, 1, 4'hF, wbuf);
    cs0 = cs_cnt;
    send_byte(8'h00, e); send_byte(8'h01, e); send_byte(8'h23, e);
    recv_byte(b, e);
    check("bp_byte0", {24'd0, b}, 32'h78);
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (!out_valid || out_data !== 8'h56) bad++;
    end
    check("bp_hold_stable", bad, 0);
    recv_byte(b, e); check("bp_byte1", {24'd0, b}, 32'h56);
    recv_byte(b, e); check("bp_byte2", {24'd0, b}, 32'h34);
    recv_byte(b, e); check("bp_byte3", {24'd0, b}, 32'h12);
    @(negedge clk);
    check("bp_cs_count", cs_cnt - cs0, 1);

    // Reset in the middle of word 2 of a write burst.
    wbuf[0] = 32'h55555555;
    write_txn(12'h301, 1, 4'hF, wbuf);
    cs0 = cs_cnt;
    send_byte(8'h9F, e); send_byte(8'h03, e); send_byte(8'h00, e);
    send_byte(8'h11, e); send_byte(8'h22, e); send_byte(8'h33, e); send_byte(8'h44, e);
    send_byte(8'hAA, e); send_byte(8'hBB, e);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    check("midrst_cs_count", cs_cnt - cs0, 1);
    ref_mem[12'h300] = 32'h44332211;
    read_txn(12'h301, 1, rbuf);
    check("midrst_word2_old", rbuf[0], 32'h55555555);
    read_txn(12'h300, 1, rbuf);
    check("midrst_word1_new", rbuf[0], 32'h44332211);

    // Random traffic with random handshake gaps against the memory model.
    rand_gap = 1;
    for (int n = 0; n < 40; n++) begin
      logic [11:0] a;
      logic [3:0]  m;
      int          len;
      a   = 12'($urandom);
      m   = 4'($urandom);
      len = $urandom_range(1, 8);
      cs0 = cs_cnt;
      acc_q.delete();
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < 8; i++) wbuf[i] = $urandom;
        write_txn(a, len, m, wbuf);
        check($sformatf("rnd%0d_wr_cs", n), cs_cnt - cs0, (m != 0) ? len : 0);
        for (int i = 0; i < acc_q.size() && i < len; i++) begin
          check($sformatf("rnd%0d_wr_addr%0d", n, i), {20'd0, acc_q[i].a}, {20'd0, a + 12'(i)});
          check($sformatf("rnd%0d_wr_data%0d", n, i), acc_q[i].wd, wbuf[i]);
        end
      end else begin
        read_txn(a, len, rbuf);
        check($sformatf("rnd%0d_rd_cs", n), cs_cnt - cs0, len);
        for (int i = 0; i < len; i++)
          check($sformatf("rnd%0d_rd%0d", n, i), rbuf[i], ref_mem[a + 12'(i)]);
      end
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
